// File: rtl/multi_strobe_ctrl.sv
// N-channel trigger-to-strobe controller: synchroniser, live-length debouncer,
// edge qualifier and a DELAY/PULSE/HOLDOFF sequencer per channel.
module multi_strobe_ctrl #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 20,
    parameter int DEB_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_HIGH = 1
) (
    input  logic                clk48,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] trig_in,
    input  logic                enable,
    input  logic [1:0]          edge_mode,
    input  logic                retrig,
    input  logic [DEB_W-1:0]    deb_len,
    input  logic [CNT_W-1:0]    delay,
    input  logic [CNT_W-1:0]    width,
    input  logic [CNT_W-1:0]    holdoff,
    input  logic                miss_clr,
    output logic [CHANNELS-1:0] strobe_out,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] miss
);

    localparam logic             STB_ON   = (ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;
    localparam logic             STB_OFF  = ~STB_ON;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [DEB_W-1:0] DEB_ZERO = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // A zero strobe width still produces a one-cycle strobe.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == CNT_ZERO) ? CNT_ONE : v;
    endfunction

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic                   s;
        logic                   d_r;
        logic                   d_q_r;
        logic [DEB_W-1:0]       deb_cnt_r;
        logic                   ev;
        logic                   miss_ev;
        state_t                 state_r;
        state_t                 state_nxt;
        logic [CNT_W-1:0]       cnt_r;
        logic [CNT_W-1:0]       cnt_nxt;
        logic [CNT_W-1:0]       width_l_r;
        logic [CNT_W-1:0]       width_l_nxt;
        logic [CNT_W-1:0]       hold_l_r;
        logic [CNT_W-1:0]       hold_l_nxt;
        logic                   strobe_r;
        logic                   busy_r;
        logic                   miss_r;

        assign s = sync_r[SYNC_STAGES-1];

        // Synchroniser, debouncer and edge-history registers.
        always_ff @(posedge clk48) begin
            if (!rst_n) begin
                sync_r    <= {SYNC_STAGES{1'b0}};
                d_r       <= 1'b0;
                d_q_r     <= 1'b0;
                deb_cnt_r <= DEB_ZERO;
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], trig_in[ch]};
                d_q_r  <= d_r;
                if (s == d_r) begin
                    deb_cnt_r <= DEB_ZERO;
                end else if (deb_cnt_r >= deb_len) begin
                    d_r       <= s;
                    deb_cnt_r <= DEB_ZERO;
                end else begin
                    deb_cnt_r <= deb_cnt_r + DEB_ONE;
                end
            end
        end

        // Edge qualification of the debounced level.
        always_comb begin
            ev = 1'b0;
            case (edge_mode)
                2'b00:   ev = d_r & ~d_q_r;
                2'b01:   ev = ~d_r & d_q_r;
                2'b10:   ev = d_r ^ d_q_r;
                default: ev = 1'b0;
            endcase
        end

        // Sequencer next-state; counters stop at 1 and never wrap.
        always_comb begin
            state_nxt   = state_r;
            cnt_nxt     = cnt_r;
            width_l_nxt = width_l_r;
            hold_l_nxt  = hold_l_r;
            miss_ev     = 1'b0;
            if (!enable) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = CNT_ZERO;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (ev) begin
                            width_l_nxt = width;
                            hold_l_nxt  = holdoff;
                            if (delay != CNT_ZERO) begin
                                state_nxt = ST_DELAY;
                                cnt_nxt   = delay;
                            end else begin
                                state_nxt = ST_PULSE;
                                cnt_nxt   = at_least_one(width);
                            end
                        end else begin
                            cnt_nxt = CNT_ZERO;
                        end
                    end
                    ST_DELAY: begin
                        miss_ev = ev;
                        if (cnt_r <= CNT_ONE) begin
                            state_nxt = ST_PULSE;
                            cnt_nxt   = at_least_one(width_l_r);
                        end else begin
                            cnt_nxt = cnt_r - CNT_ONE;
                        end
                    end
                    ST_PULSE: begin
                        if (ev && retrig) begin
                            cnt_nxt = at_least_one(width_l_r);
                        end else begin
                            miss_ev = ev;
                            if (cnt_r > CNT_ONE) begin
                                cnt_nxt = cnt_r - CNT_ONE;
                            end else if (hold_l_r != CNT_ZERO) begin
                                state_nxt = ST_HOLD;
                                cnt_nxt   = hold_l_r;
                            end else begin
                                state_nxt = ST_IDLE;
                                cnt_nxt   = CNT_ZERO;
                            end
                        end
                    end
                    ST_HOLD: begin
                        miss_ev = ev;
                        if (cnt_r <= CNT_ONE) begin
                            state_nxt = ST_IDLE;
                            cnt_nxt   = CNT_ZERO;
                        end else begin
                            cnt_nxt = cnt_r - CNT_ONE;
                        end
                    end
                    default: begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = CNT_ZERO;
                    end
                endcase
            end
        end

        // Sequencer state and registered outputs; a new miss beats miss_clr.
        always_ff @(posedge clk48) begin
            if (!rst_n) begin
                state_r   <= ST_IDLE;
                cnt_r     <= CNT_ZERO;
                width_l_r <= CNT_ZERO;
                hold_l_r  <= CNT_ZERO;
                strobe_r  <= STB_OFF;
                busy_r    <= 1'b0;
                miss_r    <= 1'b0;
            end else begin
                state_r   <= state_nxt;
                cnt_r     <= cnt_nxt;
                width_l_r <= width_l_nxt;
                hold_l_r  <= hold_l_nxt;
                strobe_r  <= (state_nxt == ST_PULSE) ? STB_ON : STB_OFF;
                busy_r    <= (state_nxt != ST_IDLE);
                if (miss_ev) begin
                    miss_r <= 1'b1;
                end else if (miss_clr) begin
                    miss_r <= 1'b0;
                end else begin
                    miss_r <= miss_r;
                end
            end
        end

        assign strobe_out[ch] = strobe_r;
        assign busy[ch]       = busy_r;
        assign miss[ch]       = miss_r;
    end

endmodule
